// File: rtl/dial_coprocessor_v2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dial_coprocessor_v2
// Purpose  : FIFO-buffered dial-rotation engine counting zero landings and
//            zero passes. Optional saturating counters: DIAL_COPROC_SAT_EN.
// Revision : 2.0 - initial release
// ============================================================================
module dial_coprocessor_v2 #(
    parameter int WIDTH_DIN     = 128,
    parameter int WIDTH_DOUT    = 128,
    parameter int WIDTH_COMPUTE = 32,
    parameter int DIAL_SIZE     = 100,
    parameter int START_POS     = 50,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH_DIN-1:0]  din,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic                  clear,
    input  logic [2:0]            sel,
    output logic [WIDTH_DOUT-1:0] dout,
    output logic                  dout_valid,
    output logic                  busy
);
    localparam int                   c_wc      = WIDTH_COMPUTE;
    localparam int                   c_aw      = $clog2(FIFO_DEPTH);
    localparam logic signed [c_wc:0] c_mod     = (c_wc+1)'(DIAL_SIZE);
    localparam logic [c_wc-1:0]      c_start   = c_wc'(START_POS);
    localparam logic [c_wc-1:0]      c_one     = c_wc'(1);
    localparam logic [c_aw:0]        c_ptr_one = (c_aw+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_REDUCE = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    function automatic logic [c_wc-1:0] f_add(input logic [c_wc-1:0] a, input logic [c_wc-1:0] b);
`ifdef DIAL_COPROC_SAT_EN
        logic [c_wc:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[c_wc] ? '1 : s[c_wc-1:0];
`else
        return a + b;
`endif
    endfunction

`ifdef DIAL_COPROC_SAT_EN
    function automatic logic f_carry(input logic [c_wc-1:0] a, input logic [c_wc-1:0] b);
        logic [c_wc:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[c_wc];
    endfunction

    logic ovf_q, ovf_d;
`endif

    state_t                 state_q, state_d;
    logic [c_wc-1:0]        mem_q [FIFO_DEPTH];
    logic [c_aw:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_wc-1:0]        rot_q, rot_d;
    logic signed [c_wc:0]   sum_q, sum_d;
    logic [c_wc-1:0]        acc_q, acc_d;
    logic                   neg_q, neg_d, pzero_q, pzero_d;
    logic [c_wc-1:0]        pos_q, pos_d, land_q, land_d, pass_q, pass_d, last_q, last_d;
    logic                   valid_q, valid_d;

    logic                   w_full, w_empty, w_push, w_zero;
    logic [c_aw:0]          w_level;
    logic [c_wc-1:0]        w_zext, w_passes;
    logic                   w_unused_din;

    assign w_unused_din = ^din[WIDTH_DIN-1:c_wc];
    assign w_level      = wr_ptr_q - rd_ptr_q;
    assign w_empty      = (wr_ptr_q == rd_ptr_q);
    assign w_full       = (w_level == (c_aw+1)'(FIFO_DEPTH));
    assign din_ready    = rst_n && !clear && !w_full;
    assign w_push       = din_valid && din_ready;
    assign busy         = (state_q != S_IDLE) || !w_empty;
    assign dout_valid   = valid_q;
    assign w_zero       = (sum_q == '0);
    assign w_zext       = {{(c_wc-1){1'b0}}, w_zero};

    // Per-step wrap count corrected to the arithmetic pass definition for
    // negative rotations, where the landing on zero itself decides the edge case.
    always_comb begin
        w_passes = acc_q;
        if (neg_q && pzero_q) begin
            w_passes = acc_q - c_one + w_zext;
`ifdef DIAL_COPROC_SAT_EN
            if (acc_q == '1) w_passes = acc_q;
`endif
        end else if (neg_q) begin
            w_passes = f_add(acc_q, w_zext);
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rot_d    = rot_q;
        sum_d    = sum_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        pzero_d  = pzero_q;
        pos_d    = pos_q;
        land_d   = land_q;
        pass_d   = pass_q;
        last_d   = last_q;
        valid_d  = 1'b0;
`ifdef DIAL_COPROC_SAT_EN
        ovf_d    = ovf_q;
`endif
        if (w_push) wr_ptr_d = wr_ptr_q + c_ptr_one;

        case (state_q)
            S_IDLE: begin
                if (!w_empty) begin
                    rot_d    = mem_q[rd_ptr_q[c_aw-1:0]];
                    rd_ptr_d = rd_ptr_q + c_ptr_one;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                sum_d   = $signed({1'b0, pos_q}) + $signed({rot_q[c_wc-1], rot_q});
                acc_d   = '0;
                neg_d   = rot_q[c_wc-1];
                pzero_d = (pos_q == '0);
                state_d = S_REDUCE;
            end
            S_REDUCE: begin
                if (sum_q[c_wc] || (sum_q >= c_mod)) begin
                    sum_d = sum_q[c_wc] ? (sum_q + c_mod) : (sum_q - c_mod);
                    acc_d = f_add(acc_q, c_one);
`ifdef DIAL_COPROC_SAT_EN
                    if (f_carry(acc_q, c_one)) ovf_d = 1'b1;
`endif
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                pos_d   = sum_q[c_wc-1:0];
                land_d  = f_add(land_q, w_zext);
                pass_d  = f_add(pass_q, w_passes);
                last_d  = w_passes;
                valid_d = 1'b1;
                state_d = S_IDLE;
`ifdef DIAL_COPROC_SAT_EN
                if (f_carry(land_q, w_zext) || f_carry(pass_q, w_passes)) ovf_d = 1'b1;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (clear) begin
            state_d  = S_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            pos_d    = c_start;
            land_d   = '0;
            pass_d   = '0;
            last_d   = '0;
            valid_d  = 1'b0;
`ifdef DIAL_COPROC_SAT_EN
            ovf_d    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rot_q    <= '0;
            sum_q    <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            pzero_q  <= 1'b0;
            pos_q    <= c_start;
            land_q   <= '0;
            pass_q   <= '0;
            last_q   <= '0;
            valid_q  <= 1'b0;
`ifdef DIAL_COPROC_SAT_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rot_q    <= rot_d;
            sum_q    <= sum_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            pzero_q  <= pzero_d;
            pos_q    <= pos_d;
            land_q   <= land_d;
            pass_q   <= pass_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
`ifdef DIAL_COPROC_SAT_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q[c_aw-1:0]] <= din[c_wc-1:0];
    end

    always_comb begin
        dout = '0;
        case (sel)
            3'd0: dout = {{(WIDTH_DOUT-c_wc){pos_q[c_wc-1]}}, pos_q};
            3'd1: dout = WIDTH_DOUT'(land_q);
            3'd2: dout = WIDTH_DOUT'(pass_q);
            3'd3: dout = WIDTH_DOUT'(last_q);
            3'd4: dout = WIDTH_DOUT'({w_level, busy});
`ifdef DIAL_COPROC_SAT_EN
            3'd7: dout = WIDTH_DOUT'(ovf_q);
`endif
            default: dout = '0;
        endcase
    end

endmodule
`default_nettype wire
